// File: rtl/gbf_flgact_pingpong_if.sv
// Producer/consumer bundle for the GBF flag/activation ping-pong buffer.
// The buffer takes the slave side; the loader and PE fetch logic take master.
interface gbf_flgact_pingpong_if #(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_WIDTH     = 28,
    parameter int NUM_BANK       = 2
) ();
    logic                          wr_valid;
    logic                          wr_ready;
    logic [SRAM_WIDTH-1:0]         wr_data;
    logic                          wr_last;
    logic                          rd_valid;
    logic                          rd_ready;
    logic [SRAM_DEPTH_BIT-1:0]     rd_addr;
    logic [SRAM_WIDTH-1:0]         rd_data;
    logic                          rd_data_valid;
    logic                          rd_done;
    logic [SRAM_DEPTH_BIT:0]       rd_len;
    logic [$clog2(NUM_BANK+1)-1:0] full_cnt;

    modport master (
        output wr_valid, wr_data, wr_last, rd_valid, rd_addr, rd_done,
        input  wr_ready, rd_ready, rd_data, rd_data_valid, rd_len, full_cnt
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, rd_valid, rd_addr, rd_done,
        output wr_ready, rd_ready, rd_data, rd_data_valid, rd_len, full_cnt
    );
endinterface

// File: rtl/gbf_flgact_pingpong.sv
// Rotating multi-bank tile buffer between the GBF flag/activation loader and
// the PE-array flag fetch. Tiles fill banks in order; the consumer randomly
// reads the oldest completed tile and releases it with rd_done. Because the
// write bank is never full and the read bank always is, the two ports never
// touch the same bank in one cycle.
module gbf_flgact_pingpong #(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_DEPTH     = 2**SRAM_DEPTH_BIT,
    parameter int SRAM_WIDTH     = 28,
    parameter int NUM_BANK       = 2
) (
    input logic                   clk,
    input logic                   rst,
    gbf_flgact_pingpong_if.slave  bus
);

    localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam int LEN_W  = SRAM_DEPTH_BIT + 1;
    localparam int CNT_W  = $clog2(NUM_BANK + 1);
    localparam logic [BANK_W-1:0]         LAST_BANK = BANK_W'(NUM_BANK - 1);
    localparam logic [SRAM_DEPTH_BIT-1:0] LAST_ADDR = SRAM_DEPTH_BIT'(SRAM_DEPTH - 1);

    logic [SRAM_WIDTH-1:0]     mem [NUM_BANK][SRAM_DEPTH];
    logic [NUM_BANK-1:0]       full;
    logic [LEN_W-1:0]          len [NUM_BANK];
    logic [BANK_W-1:0]         wr_bank;
    logic [BANK_W-1:0]         rd_bank;
    logic [SRAM_DEPTH_BIT-1:0] wr_cnt;
    logic [CNT_W-1:0]          full_cnt;
    logic [SRAM_WIDTH-1:0]     rd_data;
    logic                      rd_data_valid;

    logic wr_fire;
    logic wr_close;
    logic rd_fire;
    logic rd_release;

    // Bank pointers wrap at NUM_BANK, which need not be a power of two.
    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return (b == LAST_BANK) ? '0 : b + 1'b1;
    endfunction

    // Handshakes depend only on registered bank state.
    assign bus.wr_ready = !full[wr_bank];
    assign bus.rd_ready = full[rd_bank];
    assign bus.rd_len   = full[rd_bank] ? len[rd_bank] : '0;
    assign bus.full_cnt = full_cnt;
    assign bus.rd_data       = rd_data;
    assign bus.rd_data_valid = rd_data_valid;

    // Fire/close/release qualifiers; a tile also closes when the bank is at capacity.
    always_comb begin
        wr_fire    = bus.wr_valid && !full[wr_bank];
        wr_close   = wr_fire && (bus.wr_last || (wr_cnt == LAST_ADDR));
        rd_fire    = bus.rd_valid && full[rd_bank];
        rd_release = bus.rd_done && full[rd_bank];
    end

    // Pointer, full-flag, length and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank  <= '0;
            rd_bank  <= '0;
            wr_cnt   <= '0;
            full     <= '0;
            full_cnt <= '0;
            for (int b = 0; b < NUM_BANK; b++) begin
                len[b] <= '0;
            end
        end else begin
            if (wr_fire) begin
                if (wr_close) begin
                    wr_cnt       <= '0;
                    wr_bank      <= next_bank(wr_bank);
                    len[wr_bank] <= {1'b0, wr_cnt} + LEN_W'(1);
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (rd_release) begin
                rd_bank <= next_bank(rd_bank);
            end
            // Closing and releasing always hit different banks, so the order here is moot.
            for (int b = 0; b < NUM_BANK; b++) begin
                if (wr_close && (wr_bank == BANK_W'(b))) begin
                    full[b] <= 1'b1;
                end else if (rd_release && (rd_bank == BANK_W'(b))) begin
                    full[b] <= 1'b0;
                end
            end
            case ({wr_close, rd_release})
                2'b10:   full_cnt <= full_cnt + 1'b1;
                2'b01:   full_cnt <= full_cnt - 1'b1;
                default: full_cnt <= full_cnt;
            endcase
        end
    end

    // Bank memory write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem[wr_bank][wr_cnt] <= bus.wr_data;
        end
    end

    // Registered read port; out-of-range addresses return whatever the bank holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= mem[rd_bank][bus.rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_gbf_flgact_pingpong.sv
// Directed-plus-random bench for gbf_flgact_pingpong. A tile-queue model
// (completed tiles in arrival order, plus the partial tile) predicts every
// handshake, length, count and read word. Two instances cover 2 and 3 banks.
module tb_gbf_flgact_pingpong;

    localparam int DB    = 6;
    localparam int W     = 28;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          sel      = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_last  = 1'b0;
    logic          rd_valid = 1'b0;
    logic          rd_done  = 1'b0;
    logic [W-1:0]  wr_data  = '0;
    logic [DB-1:0] rd_addr  = '0;

    gbf_flgact_pingpong_if #(.SRAM_DEPTH_BIT(DB), .SRAM_WIDTH(W), .NUM_BANK(2)) bus2 ();
    gbf_flgact_pingpong_if #(.SRAM_DEPTH_BIT(DB), .SRAM_WIDTH(W), .NUM_BANK(3)) bus3 ();

    gbf_flgact_pingpong #(.SRAM_DEPTH_BIT(DB), .SRAM_WIDTH(W), .NUM_BANK(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    gbf_flgact_pingpong #(.SRAM_DEPTH_BIT(DB), .SRAM_WIDTH(W), .NUM_BANK(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    assign bus2.wr_valid = wr_valid & ~sel;
    assign bus2.wr_data  = wr_data;
    assign bus2.wr_last  = wr_last;
    assign bus2.rd_valid = rd_valid & ~sel;
    assign bus2.rd_addr  = rd_addr;
    assign bus2.rd_done  = rd_done & ~sel;
    assign bus3.wr_valid = wr_valid & sel;
    assign bus3.wr_data  = wr_data;
    assign bus3.wr_last  = wr_last;
    assign bus3.rd_valid = rd_valid & sel;
    assign bus3.rd_addr  = rd_addr;
    assign bus3.rd_done  = rd_done & sel;

    logic         o_wr_ready, o_rd_ready, o_rd_data_valid;
    logic [W-1:0] o_rd_data;
    logic [DB:0]  o_rd_len;
    logic [1:0]   o_full_cnt;

    assign o_wr_ready      = sel ? bus3.wr_ready      : bus2.wr_ready;
    assign o_rd_ready      = sel ? bus3.rd_ready      : bus2.rd_ready;
    assign o_rd_data_valid = sel ? bus3.rd_data_valid : bus2.rd_data_valid;
    assign o_rd_data       = sel ? bus3.rd_data       : bus2.rd_data;
    assign o_rd_len        = sel ? bus3.rd_len        : bus2.rd_len;
    assign o_full_cnt      = sel ? bus3.full_cnt      : bus2.full_cnt;

    // Reference model: completed tiles as (length queue, flat word queue).
    int           nbank = 2;
    int           tile_len_q[$];
    logic [W-1:0] word_q[$];
    logic [W-1:0] cur_q[$];
    logic [W-1:0] exp_rd_data = '0;
    bit           rd_known = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = tile_len_q.size();
        chk({tag, ".wr_ready"}, 32'(o_wr_ready), 32'(sz < nbank));
        chk({tag, ".rd_ready"}, 32'(o_rd_ready), 32'(sz > 0));
        chk({tag, ".rd_len"},   32'(o_rd_len),   (sz > 0) ? tile_len_q[0] : 0);
        chk({tag, ".full_cnt"}, 32'(o_full_cnt), sz);
    endtask

    // One clock of stimulus, then model update and checks #1 after the edge.
    task automatic step(input bit wv, input logic [W-1:0] wd, input bit wl,
                        input bit rv, input int ra, input bit rdn, input string tag);
        bit           wfire, rfire, rel;
        int           sz, flen;
        logic [W-1:0] tmp;
        sz    = tile_len_q.size();
        flen  = (sz > 0) ? tile_len_q[0] : 0;
        wfire = wv && (sz < nbank);
        rfire = rv && (sz > 0);
        rel   = rdn && (sz > 0);
        wr_valid = wv;
        wr_data  = wd;
        wr_last  = wl;
        rd_valid = rv;
        rd_addr  = DB'(ra);
        rd_done  = rdn;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        rd_valid = 1'b0;
        rd_done  = 1'b0;
        if (rfire) begin
            if (ra < flen) begin
                exp_rd_data = word_q[ra];
                rd_known    = 1'b1;
            end else begin
                rd_known = 1'b0;
            end
        end
        if (rel) begin
            for (int i = 0; i < flen; i++) tmp = word_q.pop_front();
            sz = tile_len_q.pop_front();
        end
        if (wfire) begin
            cur_q.push_back(wd);
            if (wl || (cur_q.size() == DEPTH)) begin
                tile_len_q.push_back(cur_q.size());
                foreach (cur_q[i]) word_q.push_back(cur_q[i]);
                cur_q.delete();
            end
        end
        chk({tag, ".dv"}, 32'(o_rd_data_valid), 32'(rfire));
        if (rd_known) chk({tag, ".rdata"}, 32'(o_rd_data), 32'(exp_rd_data));
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tile_len_q.delete();
        word_q.delete();
        cur_q.delete();
        exp_rd_data = '0;
        rd_known    = 1'b1;
        chk({tag, ".dv"},    32'(o_rd_data_valid), 32'(0));
        chk({tag, ".rdata"}, 32'(o_rd_data),       32'(0));
        check_state(tag);
    endtask

    task automatic write_tile(input int n, input bit use_last, input string tag);
        for (int i = 0; i < n; i++)
            step(1'b1, W'($urandom), use_last && (i == n - 1), 1'b0, 0, 1'b0, tag);
    endtask

    task automatic drain_one(input string tag);
        int flen;
        flen = tile_len_q[0];
        for (int i = 0; i < flen; i++) step(1'b0, '0, 1'b0, 1'b1, i, 1'b0, tag);
        step(1'b0, '0, 1'b0, 1'b0, 0, 1'b1, {tag, ".rel"});
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        do_reset("reset");

        // Five-word tile, back-to-back readback
        for (int i = 1; i <= 5; i++) step(1'b1, W'(i), i == 5, 1'b0, 0, 1'b0, "t1_wr");
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1, i, 1'b0, "t1_rd");
        step(1'b0, '0, 1'b0, 1'b0, 0, 1'b0, "t1_idle");
        step(1'b0, '0, 1'b0, 1'b0, 0, 1'b1, "t1_rel");

        // Auto-close at capacity, both banks full, release reopens writes
        write_tile(DEPTH, 1'b0, "t2_a");
        write_tile(DEPTH, 1'b0, "t2_b");
        step(1'b1, W'($urandom), 1'b1, 1'b0, 0, 1'b0, "t2_blocked");
        step(1'b0, '0, 1'b0, 1'b0, 0, 1'b1, "t2_rel");
        for (int i = 0; i < 8; i++)
            step(1'b0, '0, 1'b0, 1'b1, $urandom_range(0, DEPTH - 1), 1'b0, "t2_rd");
        step(1'b0, '0, 1'b0, 1'b0, 0, 1'b1, "t2_rel2");

        // Stream a tile while reading the other bank; release on the closing fire
        write_tile(20, 1'b1, "t3_a");
        for (int i = 0; i < 10; i++)
            step(1'b1, W'($urandom), i == 9, 1'b1, $urandom_range(0, 19), i == 9, "t3_cc");
        drain_one("t3_b");

        // Release and read with nothing available are ignored
        step(1'b0, '0, 1'b0, 1'b0, 0, 1'b1, "t4_done");
        step(1'b0, '0, 1'b0, 1'b1, 3, 1'b0, "t4_rv");
        write_tile(3, 1'b1, "t4_w");
        drain_one("t4_d");

        // Reset mid-tile discards the partial tile
        write_tile(3, 1'b0, "t5_part");
        do_reset("t5_rst");
        step(1'b1, W'($urandom), 1'b0, 1'b0, 0, 1'b0, "t5_w0");
        step(1'b1, W'($urandom), 1'b1, 1'b0, 0, 1'b0, "t5_w1");
        drain_one("t5_d");

        // Three banks: seven tiles of lengths 1..7 with wraparound
        sel   = 1'b1;
        nbank = 3;
        do_reset("t6_rst");
        for (int k = 1; k <= 7; k++) begin
            if (tile_len_q.size() == nbank) drain_one("t6_d");
            write_tile(k, 1'b1, "t6_w");
        end
        while (tile_len_q.size() > 0) drain_one("t6_tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
